idecode_pipe: RTL and testbench

Parametrised instruction-decode stage with an integrated 64-entry register file, a registered ID/EX output stage, and a valid/ready handshake on both sides. It sits between fetch and execute. Beyond a plain decoder it adds datapath-width scaling, sign-extended immediates, back-pressure and stall handling, a branch flush, and load-use hazard detection. An optional write-back-to-decode bypass can be compiled in.

---
 rtl/idecode_pipe.sv | 166 ++++++++++++++++
 tb/tb_idecode_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idecode_pipe.sv
// idecode_pipe: instruction-decode stage with a 64 x XLEN register file, a registered
// ID/EX output stage and valid/ready handshakes towards fetch and execute.
// Handles back-pressure, branch flush and one-cycle load-use stalls.
// XLEN must be at least 32.
// Optional macro IDECODE_BYPASS_EN: forward a same-cycle write-back to the decode read ports.
module idecode_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter logic [3:0]  OP_LOAD = 4'b1110
) (
    input  logic            clk_i,
    input  logic            rst_i,

    // Fetch side
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] pc_in_i,
    input  logic [31:0]     inst_i,
    input  logic            svpc_i,
    input  logic            flush_i,

    // Execute side
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_out_o,
    output logic [XLEN-1:0] lhs_o,
    output logic [XLEN-1:0] rhs_o,
    output logic [XLEN-1:0] imm_o,
    output logic [5:0]      rd_out_o,
    output logic [3:0]      op_out_o,
    output logic            hazard_o,

    // Write-back port
    input  logic            wb_en_i,
    input  logic [5:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i
);

    // Instruction fields
    logic [3:0] op;
    logic [5:0] rd;
    logic [5:0] rs;
    logic [5:0] rt;

    assign op = inst_i[31:28];
    assign rd = inst_i[27:22];
    assign rs = inst_i[21:16];
    assign rt = inst_i[15:10];

    // Register file
    logic [XLEN-1:0] rf_q [64];
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    // Register file write; reset wipes every entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 64; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en_i) begin
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

`ifdef IDECODE_BYPASS_EN
    // Read ports, forwarding a write that lands on this same edge
    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
        if (wb_en_i && (wb_addr_i == rs)) rs_val = wb_data_i;
        if (wb_en_i && (wb_addr_i == rt)) rt_val = wb_data_i;
    end
`else
    // Read ports return the array contents before any same-cycle write
    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
    end
`endif

    // ID/EX register state
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] lhs_q,   lhs_d;
    logic [XLEN-1:0] rhs_q,   rhs_d;
    logic [XLEN-1:0] imm_q,   imm_d;
    logic [5:0]      rd_q,    rd_d;
    logic [3:0]      op_q,    op_d;

    logic            hazard;
    logic            in_ready;
    logic [XLEN-1:0] imm_next;

    // Load-use check: rs is compared even when the pc replaces it as lhs
    always_comb begin
        hazard = valid_q && (op_q == OP_LOAD) && in_valid_i && ((rd_q == rs) || (rd_q == rt));
        // A flush always consumes the presented instruction, stalled or not
        in_ready = flush_i || ((!valid_q || out_ready_i) && !hazard);
    end

    // Immediate: inst[0] selects the long 22-bit or the short 16-bit form
    always_comb begin
        if (inst_i[0]) begin
            imm_next = {{(XLEN-22){inst_i[21]}}, inst_i[21:0]};
        end else begin
            imm_next = {{(XLEN-16){inst_i[15]}}, inst_i[15:0]};
        end
    end

    // ID/EX next state: flush, then capture, then drain, otherwise hold
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        lhs_d   = lhs_q;
        rhs_d   = rhs_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        op_d    = op_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_valid_i && in_ready) begin
            valid_d = 1'b1;
            pc_d    = pc_in_i;
            lhs_d   = svpc_i ? pc_in_i : rs_val;
            rhs_d   = rt_val;
            imm_d   = imm_next;
            rd_d    = rd;
            op_d    = op;
        end else if (out_ready_i) begin
            // Covers the load-use case: the load drains and a bubble follows
            valid_d = 1'b0;
        end
    end

    // ID/EX register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign hazard_o    = hazard;
    assign out_valid_o = valid_q;
    assign pc_out_o    = pc_q;
    assign lhs_o       = lhs_q;
    assign rhs_o       = rhs_q;
    assign imm_o       = imm_q;
    assign rd_out_o    = rd_q;
    assign op_out_o    = op_q;

endmodule

// File: tb/tb_idecode_pipe.sv
// Self-checking bench for idecode_pipe: directed steps followed by a random phase,
// all compared against a behavioural model of the decode stage.
module tb_idecode_pipe;

    localparam int unsigned XLEN = 32;
    localparam logic [3:0]  LOAD = 4'b1110;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc_in;
    logic [31:0]     inst;
    logic            svpc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [XLEN-1:0] imm;
    logic [5:0]      rd_out;
    logic [3:0]      op_out;
    logic            hazard;
    logic            wb_en;
    logic [5:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    idecode_pipe #(
        .XLEN    (XLEN),
        .OP_LOAD (LOAD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .pc_in_i     (pc_in),
        .inst_i      (inst),
        .svpc_i      (svpc),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pc_out_o    (pc_out),
        .lhs_o       (lhs),
        .rhs_o       (rhs),
        .imm_o       (imm),
        .rd_out_o    (rd_out),
        .op_out_o    (op_out),
        .hazard_o    (hazard),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: register array plus the instruction sitting in ID/EX
    logic [XLEN-1:0] m_rf [64];
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_lhs, m_rhs, m_imm;
    logic [5:0]      m_rd;
    logic [3:0]      m_op;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hazard();
        return m_valid && m_op == LOAD && in_valid &&
               (m_rd == inst[21:16] || m_rd == inst[15:10]);
    endfunction

    function automatic logic m_ready();
        return flush || ((!m_valid || out_ready) && !m_hazard());
    endfunction

    function automatic logic [XLEN-1:0] rd_reg(input logic [5:0] a);
        logic [XLEN-1:0] v;
        v = m_rf[a];
`ifdef IDECODE_BYPASS_EN
        if (wb_en && wb_addr == a) v = wb_data;
`endif
        return v;
    endfunction

    // Apply one clock edge to the model using the current inputs
    task automatic model_edge();
        logic acc;
        acc = in_valid && m_ready();
        if (rst) begin
            for (int i = 0; i < 64; i++) m_rf[i] = '0;
            m_valid = 0; m_pc = 0; m_lhs = 0; m_rhs = 0; m_imm = 0; m_rd = 0; m_op = 0;
        end else begin
            if (flush) begin
                m_valid = 0;
            end else if (acc) begin
                m_valid = 1;
                m_pc    = pc_in;
                m_lhs   = svpc ? pc_in : rd_reg(inst[21:16]);
                m_rhs   = rd_reg(inst[15:10]);
                m_imm   = inst[0] ? XLEN'($signed(inst[21:0])) : XLEN'($signed(inst[15:0]));
                m_rd    = inst[27:22];
                m_op    = inst[31:28];
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (wb_en) m_rf[wb_addr] = wb_data;
        end
    endtask

    // One cycle: check combinational outputs mid-cycle, clock, then check registers
    task automatic cycle();
        #4;
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
        chk("hazard", {31'b0, hazard}, {31'b0, m_hazard()});
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("pc_out", pc_out, m_pc);
            chk("lhs", lhs, m_lhs);
            chk("rhs", rhs, m_rhs);
            chk("imm", imm, m_imm);
            chk("rd_out", {26'b0, rd_out}, {26'b0, m_rd});
            chk("op_out", {28'b0, op_out}, {28'b0, m_op});
        end
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; svpc = 0; flush = 0; out_ready = 1;
        wb_en = 0; wb_addr = 0; wb_data = 0; pc_in = 0; inst = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [XLEN-1:0] d);
        idle();
        wb_en = 1; wb_addr = a; wb_data = d;
        cycle();
    endtask

    logic [XLEN-1:0] held_pc;

    initial begin
        for (int i = 0; i < 64; i++) m_rf[i] = '0;
        m_valid = 0; m_pc = 0; m_lhs = 0; m_rhs = 0; m_imm = 0; m_rd = 0; m_op = 0;
        idle();
        @(posedge clk);
        #1;

        // Reset: everything cleared, in_ready follows its equation
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_lhs", lhs, 32'd0);
        chk("rst_rhs", rhs, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_rd_op", {22'b0, rd_out, op_out}, 32'd0);
        #4;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        wr(6'd5, 32'h0000_1234);
        wr(6'd3, 32'h0000_0011);

        // Short immediate, operand from the register file
        idle();
        in_valid = 1; pc_in = 32'h10; inst = {4'h0, 6'd1, 6'd5, 16'h8000};
        cycle();
        chk("tp1_lhs", lhs, 32'h0000_1234);
        chk("tp1_imm", imm, 32'hFFFF_8000);
        chk("tp1_valid", {31'b0, out_valid}, 32'd1);

        // pc selected as lhs, long immediate
        in_valid = 1; svpc = 1; pc_in = 32'h40; inst = {4'h2, 6'd9, 22'h3F_FFFF};
        cycle();
        chk("tp2_lhs", lhs, 32'h40);
        chk("tp2_imm", imm, 32'hFFFF_FFFF);
        chk("tp2_rd", {26'b0, rd_out}, 32'd9);

        // Back-pressure: outputs frozen, nothing accepted
        held_pc = pc_out;
        svpc = 0; out_ready = 0; pc_in = 32'h80; inst = {4'h3, 6'd2, 6'd3, 6'd5, 10'h001};
        repeat (3) begin
            cycle();
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_pc_frozen", pc_out, held_pc);
        end
        out_ready = 1;
        cycle();
        chk("bp_capture_pc", pc_out, 32'h80);

        // Load-use: one bubble, then the dependent instruction is accepted
        pc_in = 32'h90; inst = {LOAD, 6'd7, 6'd1, 6'd2, 10'h000};
        cycle();
        pc_in = 32'h94; inst = {4'h1, 6'd8, 6'd7, 6'd4, 10'h000};
        #1;
        chk("lu_hazard", {31'b0, hazard}, 32'd1);
        chk("lu_in_ready", {31'b0, in_ready}, 32'd0);
        cycle();
        chk("lu_bubble", {31'b0, out_valid}, 32'd0);
        cycle();
        chk("lu_accept_pc", pc_out, 32'h94);
        chk("lu_accept_valid", {31'b0, out_valid}, 32'd1);

        // Flush with a live ID/EX entry and a presented instruction
        flush = 1; pc_in = 32'hA0; inst = {4'h4, 6'd3, 6'd1, 6'd1, 10'h000};
        cycle();
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        idle();
        cycle();
        chk("fl_dropped", {31'b0, out_valid}, 32'd0);

        // Same-cycle write-back against a read of the same register
        in_valid = 1; pc_in = 32'hB0; inst = {4'h5, 6'd4, 6'd3, 6'd0, 10'h000};
        wb_en = 1; wb_addr = 6'd3; wb_data = 32'hAA;
        cycle();
`ifdef IDECODE_BYPASS_EN
        chk("byp_lhs", lhs, 32'hAA);
`else
        chk("byp_lhs", lhs, 32'h11);
`endif

        // Random phase with narrow register ranges so hazards and bypasses are frequent
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            svpc      = ($urandom_range(0, 3) == 0);
            pc_in     = $urandom;
            inst      = $urandom;
            inst[27:22] = 6'($urandom_range(0, 7));
            inst[21:16] = 6'($urandom_range(0, 7));
            inst[15:10] = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) inst[31:28] = LOAD;
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_addr   = 6'($urandom_range(0, 7));
            wb_data   = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
